calc_sequencer: RTL and testbench

- Owns the single BRAM port that holds operands A (addr 0), B (addr 1) and the result (addr 2).
- Arbitrates between operand writes from the button-input logic and its own compute sequence.
- On a go pulse it reads A and B, launches the arithmetic unit with a start/done handshake, then writes the result to addr 2.
- Sits between the data-input block, the operand BRAM and the ALU/display path.

---
 rtl/calc_pkg.sv | 29 ++
 rtl/calc_timeout_timer.sv | 27 ++
 rtl/calc_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants and types for the calculator operand/result sequencer
package calc_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_RD_A     = 3'd1;
    localparam state_t ST_RD_B     = 3'd2;
    localparam state_t ST_CAP_B    = 3'd3;
    localparam state_t ST_START    = 3'd4;
    localparam state_t ST_WAIT_ALU = 3'd5;
    localparam state_t ST_WR_RES   = 3'd6;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3
    } calc_op_e;

    localparam int ADDR_A   = 0;
    localparam int ADDR_B   = 1;
    localparam int ADDR_RES = 2;

    // Signed range of the 4-digit seven-segment display
    localparam int DEC_MAX = 999;
    localparam int DEC_MIN = -999;

endpackage

// File: rtl/calc_timeout_timer.sv
// rtl/calc_timeout_timer.sv - loadable down-counter with zero-reached expiry flag
module calc_timeout_timer #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - BRAM port owner sequencing operand reads, ALU launch and result store; CALC_SEQ_SATURATE_EN clamps result
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 2,
    parameter int OP_W        = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    input  logic              i_go,
    input  logic [OP_W-1:0]   i_op,
    output logic              o_bram_en,
    output logic              o_bram_we,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic [DATA_W-1:0] o_bram_din,
    input  logic [DATA_W-1:0] i_bram_dout,
    output logic              o_alu_start,
    output logic [OP_W-1:0]   o_alu_op,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    input  logic              i_alu_done,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic              i_alu_err,
    output logic [DATA_W-1:0] o_result,
    output logic              o_result_valid,
    output logic              o_busy,
    output logic              o_error
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC);

    state_t            r_state;
    logic              r_go_pend;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [DATA_W-1:0] r_res_hold;
    logic [DATA_W-1:0] r_result;
    logic              r_result_valid;
    logic              r_error;

    logic              w_go_start;
    logic              w_slot_ok;
    logic              w_tmr_load;
    logic              w_tmr_dec;
    logic              w_tmr_exp;
    logic [DATA_W-1:0] w_res;

    // A write always wins the IDLE cycle; a go seen alongside it waits in r_go_pend
    assign w_go_start = (r_state == ST_IDLE) && !i_wr_req && (i_go || r_go_pend);
    assign w_slot_ok  = (i_wr_addr == ADDR_W'(ADDR_A)) || (i_wr_addr == ADDR_W'(ADDR_B));
    assign w_tmr_load = (r_state == ST_START);
    assign w_tmr_dec  = (r_state == ST_WAIT_ALU);

`ifdef CALC_SEQ_SATURATE_EN
    always_comb begin
        w_res = i_alu_result;
        if ($signed(i_alu_result) > DEC_MAX) begin
            w_res = DATA_W'(DEC_MAX);
        end else if ($signed(i_alu_result) < DEC_MIN) begin
            w_res = DATA_W'(DEC_MIN);
        end
    end
`else
    assign w_res = i_alu_result;
`endif

    // Loaded with TIMEOUT_CYC-2 so that error rises TIMEOUT_CYC cycles after the start pulse
    calc_timeout_timer #(
        .CNT_W(TMR_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_tmr_load),
        .i_load_val(TMR_W'(TIMEOUT_CYC - 2)),
        .i_dec     (w_tmr_dec),
        .o_expired (w_tmr_exp)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_go_pend      <= 1'b0;
            r_op           <= '0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_res_hold     <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_go_start) begin
                        r_state        <= ST_RD_A;
                        r_go_pend      <= 1'b0;
                        r_error        <= 1'b0;
                        r_result_valid <= 1'b0;
                        if (i_go) begin
                            r_op <= i_op;
                        end
                    end else if (i_wr_req && i_go) begin
                        r_go_pend <= 1'b1;
                        r_op      <= i_op;
                    end
                end
                ST_RD_A: begin
                    r_state <= ST_RD_B;
                end
                ST_RD_B: begin
                    r_alu_a <= i_bram_dout;
                    r_state <= ST_CAP_B;
                end
                ST_CAP_B: begin
                    r_alu_b <= i_bram_dout;
                    r_state <= ST_START;
                end
                ST_START: begin
                    r_state <= ST_WAIT_ALU;
                end
                ST_WAIT_ALU: begin
                    if (i_alu_done) begin
                        if (i_alu_err) begin
                            r_error <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_res_hold <= w_res;
                            r_state    <= ST_WR_RES;
                        end
                    end else if (w_tmr_exp) begin
                        r_error <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_WR_RES: begin
                    r_result       <= r_res_hold;
                    r_result_valid <= 1'b1;
                    r_state        <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // The IDLE write path is gated by reset so every output is low while reset is held
    always_comb begin
        o_bram_en   = 1'b0;
        o_bram_we   = 1'b0;
        o_bram_addr = '0;
        o_bram_din  = '0;
        o_wr_ack    = 1'b0;
        o_alu_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_wr_req && !reset) begin
                    o_bram_en   = 1'b1;
                    o_bram_we   = w_slot_ok;
                    o_bram_addr = i_wr_addr;
                    o_bram_din  = i_wr_data;
                    o_wr_ack    = 1'b1;
                end
            end
            ST_RD_A: begin
                o_bram_en   = 1'b1;
                o_bram_addr = ADDR_W'(ADDR_A);
            end
            ST_RD_B: begin
                o_bram_en   = 1'b1;
                o_bram_addr = ADDR_W'(ADDR_B);
            end
            ST_START: begin
                o_alu_start = 1'b1;
            end
            ST_WR_RES: begin
                o_bram_en   = 1'b1;
                o_bram_we   = 1'b1;
                o_bram_addr = ADDR_W'(ADDR_RES);
                o_bram_din  = r_res_hold;
            end
            default: begin
            end
        endcase
    end

    assign o_alu_op       = r_op;
    assign o_alu_a        = r_alu_a;
    assign o_alu_b        = r_alu_b;
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_error        = r_error;
    assign o_busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - directed self-checking bench for calc_sequencer
module tb_calc_sequencer;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_req = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ack;
    logic        go = 1'b0;
    logic [2:0]  op = '0;
    logic        bram_en;
    logic        bram_we;
    logic [1:0]  bram_addr;
    logic [15:0] bram_din;
    logic [15:0] bram_dout = '0;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = '0;
    logic        alu_err = 1'b0;
    logic [15:0] result;
    logic        result_valid;
    logic        busy;
    logic        error;

    logic [15:0] mem [0:3] = '{default: 16'h0000};
    int          cyc = 0;
    int          res_wr_cnt = 0;
    int          ack_cnt = 0;
    int          total = 0;
    int          bad = 0;
    int          s_cyc;
    int          wr_before;
    logic [15:0] sat_pos;
    logic [15:0] sat_neg;

    calc_sequencer #(
        .DATA_W(16), .ADDR_W(2), .OP_W(3), .TIMEOUT_CYC(1024)
    ) dut (
        .clk(clk), .reset(reset),
        .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
        .i_go(go), .i_op(op),
        .o_bram_en(bram_en), .o_bram_we(bram_we), .o_bram_addr(bram_addr),
        .o_bram_din(bram_din), .i_bram_dout(bram_dout),
        .o_alu_start(alu_start), .o_alu_op(alu_op), .o_alu_a(alu_a), .o_alu_b(alu_b),
        .i_alu_done(alu_done), .i_alu_result(alu_result), .i_alu_err(alu_err),
        .o_result(result), .o_result_valid(result_valid), .o_busy(busy), .o_error(error)
    );

    always #5 clk = ~clk;

    // Read-first single-port BRAM with one-cycle read latency
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            bram_dout <= mem[bram_addr];
        end
        if (bram_en && bram_we && bram_addr == 2'd2) res_wr_cnt <= res_wr_cnt + 1;
        if (wr_ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(output int s);
        int n = 0;
        while (alu_start !== 1'b1 && n < 12) begin
            @(negedge clk); #1;
            n++;
        end
        chk("start_seen", {31'd0, alu_start}, 32'd1);
        s = cyc;
    endtask

    task automatic go_pulse(input logic [2:0] o);
        @(negedge clk); go = 1'b1; op = o;
        @(negedge clk); go = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef CALC_SEQ_SATURATE_EN
        sat_pos = 16'd999;
        sat_neg = 16'hFC19;
`else
        sat_pos = 16'd1500;
        sat_neg = 16'hF830;
`endif
        // Reset state, with a write request pending to prove the gating
        wr_req = 1'b1; wr_addr = 2'd0; wr_data = 16'h1234;
        @(negedge clk); #1;
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_bram_en", bram_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_error", error, 0);
        chk("rst_alu_start", alu_start, 0);
        wr_req = 1'b0;
        @(negedge clk); reset = 1'b0;

        // A=25, B=-7, ADD -> 18
        @(negedge clk); wr_req = 1'b1; wr_addr = 2'd0; wr_data = 16'd25; #1;
        chk("t1_ack_a", wr_ack, 1);
        chk("t1_we_a", bram_we, 1);
        @(negedge clk); wr_addr = 2'd1; wr_data = 16'hFFF9; #1;
        chk("t1_ack_b", wr_ack, 1);
        chk("t1_addr_b", bram_addr, 1);
        @(negedge clk); wr_req = 1'b0; go = 1'b1; op = OP_ADD; #1;
        chk("t1_idle_on_go", busy, 0);
        @(negedge clk); go = 1'b0; #1;
        chk("t1_c1_addr", bram_addr, 0);
        chk("t1_c1_en", bram_en, 1);
        chk("t1_c1_busy", busy, 1);
        chk("t1_c1_start", alu_start, 0);
        @(negedge clk); #1;
        chk("t1_c2_start", alu_start, 0);
        @(negedge clk); #1;
        chk("t1_c3_start", alu_start, 0);
        chk("t1_alu_a", alu_a, 16'd25);
        @(negedge clk); #1;
        chk("t1_c4_start", alu_start, 1);
        chk("t1_alu_b", alu_b, 16'hFFF9);
        chk("t1_alu_op", alu_op, OP_ADD);
        repeat (4) @(negedge clk);
        @(negedge clk); alu_done = 1'b1; alu_result = 16'd18;
        @(negedge clk); alu_done = 1'b0; #1;
        chk("t1_wr_addr", bram_addr, 2);
        chk("t1_wr_we", bram_we, 1);
        chk("t1_wr_din", bram_din, 16'd18);
        @(negedge clk); #1;
        chk("t1_result", result, 16'd18);
        chk("t1_rv", result_valid, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_mem2", mem[2], 16'd18);
        chk("t1_ack_cnt", ack_cnt, 2);

        // Write and go in the same cycle: write first, then sequence reads new A
        @(negedge clk); wr_req = 1'b1; wr_addr = 2'd0; wr_data = 16'd100; go = 1'b1; op = OP_SUB; #1;
        chk("t2_ack", wr_ack, 1);
        chk("t2_busy0", busy, 0);
        @(negedge clk); wr_req = 1'b0; go = 1'b0; #1;
        chk("t2_pend_idle", busy, 0);
        chk("t2_mem0", mem[0], 16'd100);
        wait_start(s_cyc);
        chk("t2_alu_a", alu_a, 16'd100);
        chk("t2_alu_op", alu_op, OP_SUB);

        // Write stalled while busy; go ignored while busy
        @(negedge clk); wr_req = 1'b1; wr_addr = 2'd1; wr_data = 16'd42; #1;
        chk("t3_stall_wait", wr_ack, 0);
        @(negedge clk); go = 1'b1; op = OP_DIV; #1;
        chk("t3_stall_wait2", wr_ack, 0);
        chk("t3_op_stable", alu_op, OP_SUB);
        @(negedge clk); go = 1'b0; alu_done = 1'b1; alu_result = 16'd107;
        @(negedge clk); alu_done = 1'b0; #1;
        chk("t3_stall_wr", wr_ack, 0);
        chk("t3_res_din", bram_din, 16'd107);
        @(negedge clk); #1;
        chk("t3_ack_idle", wr_ack, 1);
        chk("t3_ack_din", bram_din, 16'd42);
        chk("t3_ack_addr", bram_addr, 1);
        @(negedge clk); wr_req = 1'b0; #1;
        chk("t3_go_not_queued", busy, 0);
        chk("t3_result", result, 16'd107);
        chk("t3_mem1", mem[1], 16'd42);

        // Divide by zero: error, no result write
        @(negedge clk); wr_req = 1'b1; wr_addr = 2'd1; wr_data = 16'd0; #1;
        chk("t4_ack_b0", wr_ack, 1);
        @(negedge clk); wr_req = 1'b0;
        go_pulse(OP_DIV);
        wait_start(s_cyc);
        chk("t4_alu_b", alu_b, 0);
        chk("t4_alu_op", alu_op, OP_DIV);
        wr_before = res_wr_cnt;
        @(negedge clk); alu_done = 1'b1; alu_err = 1'b1;
        @(negedge clk); alu_done = 1'b0; alu_err = 1'b0; #1;
        chk("t4_error", error, 1);
        chk("t4_busy", busy, 0);
        chk("t4_rv", result_valid, 0);
        chk("t4_no_write", res_wr_cnt, wr_before);
        @(negedge clk); wr_req = 1'b1; wr_addr = 2'd2; wr_data = 16'd555; #1;
        chk("t4_ack_addr2", wr_ack, 1);
        chk("t4_we_addr2", bram_we, 0);
        chk("t4_error_sticky", error, 1);
        @(negedge clk); wr_req = 1'b0;

        // Next go clears error; ALU never answers -> timeout
        go_pulse(OP_ADD); #1;
        chk("t5_err_clr", error, 0);
        chk("t5_busy", busy, 1);
        wait_start(s_cyc);
        for (int n = 0; n < 1100 && error !== 1'b1; n++) begin
            @(negedge clk); #1;
        end
        chk("t5_timeout_delay", cyc - s_cyc, 1024);
        chk("t5_busy_end", busy, 0);
        chk("t5_rv", result_valid, 0);
        chk("t5_mem2_kept", mem[2], 16'd107);

        // Reset in WAIT_ALU aborts; late done ignored
        go_pulse(OP_MUL);
        wait_start(s_cyc);
        @(negedge clk); reset = 1'b1; #1;
        chk("t6_busy", busy, 0);
        chk("t6_alu_a", alu_a, 0);
        chk("t6_alu_op", alu_op, 0);
        chk("t6_result", result, 0);
        chk("t6_bram_en", bram_en, 0);
        wr_before = res_wr_cnt;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); alu_done = 1'b1; alu_result = 16'd77;
        @(negedge clk); alu_done = 1'b0; #1;
        chk("t6_late_busy", busy, 0);
        chk("t6_late_rv", result_valid, 0);
        chk("t6_no_write", res_wr_cnt, wr_before);
        chk("t6_mem0_kept", mem[0], 16'd100);

        // Display-range clamp (raw value when the clamp is not built in)
        go_pulse(OP_MUL);
        wait_start(s_cyc);
        @(negedge clk); alu_done = 1'b1; alu_result = 16'd1500;
        @(negedge clk); alu_done = 1'b0; #1;
        chk("t7_din_pos", bram_din, sat_pos);
        @(negedge clk); #1;
        chk("t7_result_pos", result, sat_pos);
        chk("t7_error_pos", error, 0);
        go_pulse(OP_MUL);
        wait_start(s_cyc);
        @(negedge clk); alu_done = 1'b1; alu_result = 16'hF830;
        @(negedge clk); alu_done = 1'b0;
        @(negedge clk); #1;
        chk("t7_result_neg", result, sat_neg);
        chk("t7_mem2_neg", mem[2], sat_neg);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
